// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: serial shift-add-3 binary-to-BCD engine shared by two
// requesters through a round-robin scheduler. Rev 1.0
`default_nettype none

module bcd_conv_sched #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic [WIDTH-1:0]      bin0,
   input  logic                  req1,
   input  logic [WIDTH-1:0]      bin1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  busy,
   output logic                  valid,
   output logic                  owner,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic [BW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sticky_q, sticky_d;
   logic              own_q, own_d;
   logic              ptr_q, ptr_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              owner_q, owner_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic              ovf_q, ovf_d;

   logic [BW-1:0]     adj;
   logic              take;
   logic              pick1;

   // Digits are at most 9 before adjustment, so the 4-bit add never wraps.
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // ptr_q holds the index granted last; a tie goes to the other one.
   assign take  = (state_q != SHIFT) && (req0 || req1);
   assign pick1 = req1 && (!req0 || !ptr_q);

   always_comb begin
      state_d  = state_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      own_d    = own_q;
      ptr_d    = ptr_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      valid_d  = 1'b0;
      owner_d  = owner_q;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;

      case (state_q)
         SHIFT: begin
            acc_d    = {adj[BW-2:0], opnd_q[WIDTH-1]};
            opnd_d   = {opnd_q[WIDTH-2:0], 1'b0};
            sticky_d = sticky_q | adj[BW-1];
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d   = {adj[BW-2:0], opnd_q[WIDTH-1]};
               ovf_d   = sticky_q | adj[BW-1];
               owner_d = own_q;
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            if (take) begin
               opnd_d   = pick1 ? bin1 : bin0;
               acc_d    = '0;
               sticky_d = 1'b0;
               cnt_d    = CW'(WIDTH);
               own_d    = pick1;
               ptr_d    = pick1;
               gnt0_d   = !pick1;
               gnt1_d   = pick1;
               state_d  = SHIFT;
            end
         end
      endcase

      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         own_q    <= 1'b0;
         ptr_q    <= 1'b1;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         owner_q  <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         own_q    <= own_d;
         ptr_q    <= ptr_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         owner_q  <= owner_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign busy  = busy_q;
   assign valid = valid_q;
   assign owner = owner_q;
   assign bcd   = bcd_q;
   assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Serial (one bit per clock) binary-to-BCD shift-add-3 engine, shared by two requesters through a round-robin scheduler.
- Replaces per-consumer combinational converters where area matters; e.g. two 7-segment display paths share one engine.
- Handles request arbitration, operand capture, the WIDTH-step shift sequence, and result/owner delivery with a valid pulse.

Parameters:
- WIDTH, 8, binary operand width in bits (>=2).
- DIGITS, 3, number of BCD digits produced; the result is 4*DIGITS bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req0  input  1  requester 0 conversion request; held high until gnt0 is seen.
- bin0  input  WIDTH  requester 0 operand; sampled on the accepting edge only.
- req1  input  1  requester 1 conversion request.
- bin1  input  WIDTH  requester 1 operand.
- gnt0  output  1  one-cycle pulse: requester 0 operand was accepted.
- gnt1  output  1  one-cycle pulse: requester 1 operand was accepted.
- busy  output  1  high while the engine is shifting.
- valid  output  1  one-cycle pulse: bcd, ovf and owner are new.
- owner  output  1  requester index the current result belongs to.
- bcd  output  4*DIGITS  packed BCD result; most significant digit in the top nibble. Holds its value until the next valid.
- ovf  output  1  result did not fit in DIGITS digits; updated with valid.

Behaviour:
- Reset: an edge with rst_n=0 does all of the following; it overrides everything and aborts any conversion with no valid.
  - state=IDLE.
  - gnt0=gnt1=0, busy=0, valid=0, owner=0, bcd=0, ovf=0.
  - Round-robin pointer set so requester 0 wins the first tie.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- Accept edge E0, taken in IDLE or DONE when req0|req1=1:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester not granted last; the pointer flips to the winner.
  - Actions at E0: latch the selected bin into the operand shift register, clear the digit accumulator, bit counter=WIDTH, record the owner, set the matching gnt=1 for exactly one cycle, state=SHIFT.
- SHIFT, edges E1..E_WIDTH, each edge:
  - Add 3 to every 4-bit digit whose value is >=5.
  - Shift the {digits, operand} concatenation left 1; the operand MSB enters digit-0 LSB.
  - The bit leaving the top digit MSB is ORed into a sticky overflow flag; the flag is cleared at E0.
  - Decrement the counter.
- Result delivery at E_WIDTH:
  - bcd and ovf take the final accumulator and overflow flag; owner takes the recorded requester.
  - valid=1 and state=DONE.
  - valid is high in the single cycle following E_WIDTH.
- DONE: at the next edge valid=0. That same edge may accept a new request (back-to-back); otherwise state=IDLE.
- Latency and throughput: valid follows the accept edge by WIDTH edges. Back-to-back throughput is one result per WIDTH+1 cycles.
- busy=1 exactly in cycles where state=SHIFT.
- req and bin changes during SHIFT are ignored. A held req is accepted at the DONE edge.
- A requester that keeps req high after its gnt is re-arbitrated as a new request.
- Arithmetic: add-3 is a 4-bit add without carry into the next digit; the pre-adjust value is always <=9.
- Operand and digit registers have fixed widths; nothing depends on the operand contents except the result.

Test Plan:
- Reset: rst_n=0 for 2 edges with req0=1 -> all outputs 0, no gnt. After release, the first accept is from requester 0.
- Single conversion (WIDTH=8, DIGITS=3): req0=1, bin0=8'd255.
  - Expect gnt0 pulse 1 cycle.
  - busy high for 8 cycles.
  - valid 8 edges after accept with bcd=12'h255, ovf=0, owner=0.
  - Repeat with 0 -> 12'h000, 99 -> 12'h099, 128 -> 12'h128.
- Contention: req0=req1=1 on the same edge, bin0=8'd42, bin1=8'd199.
  - Requester 0 is served first: bcd=12'h042, owner=0.
  - Requester 1 is accepted on the DONE edge: bcd=12'h199, owner=1.
  - The two valid pulses are 9 cycles apart.
  - A third simultaneous request is granted to requester 0 again.
- Operand stability: accept bin1=8'd7, then change bin1 to 8'd250 during SHIFT -> bcd=12'h007.
- Reset mid-conversion: rst_n=0 on the 4th SHIFT edge -> no valid, bcd=0, busy=0. The next request converts correctly.
- Overflow (DIGITS=2): 8'd200 -> bcd=8'h00, ovf=1; 8'd99 -> bcd=8'h99, ovf=0.
